// File: rtl/brick_hit_scheduler.sv
// ---------------------------------------------------------------------------
// brick_hit_scheduler
//   Time-multiplexed bullet-vs-map collision scheduler. A refresh_tick
//   snapshots the three bullet boxes, then every map object (bricks first,
//   then irons) is walked one per clock through a single overlap test. The
//   block owns the brick-alive bitmap: an alive brick is destroyed by the
//   highest-priority overlapping bullet (slot 0 > 1 > 2), irons report every
//   overlapping bullet. Per-slot hit flags are sticky across the scan and
//   presented as a one-cycle pulse at the end.
//
// Ports
//   clk_50MHz, reset      clock, asynchronous active-low reset
//   refresh_tick          starts a scan when idle (ignored while busy)
//   map_reload            restores all bricks, aborts any scan, no report
//   bul_valid[2:0]        slot in flight ([0]=player,[1]=enemy,[2]=enemy_2)
//   bul_xl/xr/yt/yb       packed 3x10b bullet edges, slot k at [10k+9:10k]
//   scan_idx              object index presented to the position table
//   obj_x, obj_y          origin of object scan_idx (same-cycle table)
//   brick_alive           1 = brick present
//   hit[2:0]              one-cycle per-slot hit pulse at end of scan
//   busy                  scan in progress (LATCH through REPORT)
//   scan_done             one-cycle pulse with hit
//
// Configuration
//   BRICK_HIT_SCHED_KILL_LOG_EN: adds kill_valid / kill_idx / kill_src, a
//   one-cycle record of each brick destruction (index and winning slot),
//   asserted together with the brick_alive bit dropping.
// ---------------------------------------------------------------------------
module brick_hit_scheduler #(
  parameter int NUM_BRICK = 100,
  parameter int NUM_IRON  = 10,
  parameter int BRICK_SZ  = 15,
  parameter int IRON_SZ   = 31,
  parameter int IDX_W     = 7
) (
  input  logic                 clk_50MHz,
  input  logic                 reset,
  input  logic                 refresh_tick,
  input  logic                 map_reload,
  input  logic [2:0]           bul_valid,
  input  logic [29:0]          bul_xl,
  input  logic [29:0]          bul_xr,
  input  logic [29:0]          bul_yt,
  input  logic [29:0]          bul_yb,
  output logic [IDX_W-1:0]     scan_idx,
  input  logic [9:0]           obj_x,
  input  logic [9:0]           obj_y,
  output logic [NUM_BRICK-1:0] brick_alive,
  output logic [2:0]           hit,
  output logic                 busy,
`ifdef BRICK_HIT_SCHED_KILL_LOG_EN
  output logic                 kill_valid,
  output logic [IDX_W-1:0]     kill_idx,
  output logic [1:0]           kill_src,
`endif
  output logic                 scan_done
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BRICK + NUM_IRON - 1);
  localparam logic [IDX_W-1:0] BRICK_END = IDX_W'(NUM_BRICK);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_SCAN, S_REPORT} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       scan_idx_q, scan_idx_d;
  logic [NUM_BRICK-1:0]   alive_q, alive_d;
  logic [2:0]             vld_q, vld_d;
  logic [2:0][9:0]        xl_q, xl_d, xr_q, xr_d, yt_q, yt_d, yb_q, yb_d;
  logic [2:0]             flags_q, flags_d;
  logic [2:0]             hit_q, hit_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
`ifdef BRICK_HIT_SCHED_KILL_LOG_EN
  logic                   kill_valid_q, kill_valid_d;
  logic [IDX_W-1:0]       kill_idx_q, kill_idx_d;
  logic [1:0]             kill_src_q, kill_src_d;
`endif

  // Overlap test for the object under scan. Far edges are formed at 11 bits
  // so origin+extent near the top of the 10-bit range cannot wrap.
  logic        is_brick;
  logic        cur_alive;
  logic [10:0] obj_sz, x_far, y_far;
  logic [2:0]  ovl;
  logic [2:0]  win_oh;
  logic [1:0]  win_src;

  assign is_brick  = scan_idx_q < BRICK_END;
  assign cur_alive = is_brick && alive_q[scan_idx_q];
  assign obj_sz    = is_brick ? 11'(BRICK_SZ) : 11'(IRON_SZ);
  assign x_far     = {1'b0, obj_x} + obj_sz;
  assign y_far     = {1'b0, obj_y} + obj_sz;

  for (genvar k = 0; k < 3; k++) begin : g_slot
    assign ovl[k] = vld_q[k]
                 && ({1'b0, yt_q[k]} < y_far) && (yb_q[k] > obj_y)
                 && ({1'b0, xl_q[k]} < x_far) && (xr_q[k] > obj_x);
  end

  // Fixed priority: player beats enemy beats enemy_2.
  always_comb begin
    win_oh  = 3'b000;
    win_src = 2'd0;
    if (ovl[0]) begin
      win_oh  = 3'b001;
      win_src = 2'd0;
    end else if (ovl[1]) begin
      win_oh  = 3'b010;
      win_src = 2'd1;
    end else if (ovl[2]) begin
      win_oh  = 3'b100;
      win_src = 2'd2;
    end
  end

  always_comb begin
    state_d    = state_q;
    scan_idx_d = scan_idx_q;
    alive_d    = alive_q;
    vld_d      = vld_q;
    xl_d       = xl_q;
    xr_d       = xr_q;
    yt_d       = yt_q;
    yb_d       = yb_q;
    flags_d    = flags_q;
    hit_d      = 3'b000;
    done_d     = 1'b0;
`ifdef BRICK_HIT_SCHED_KILL_LOG_EN
    kill_valid_d = 1'b0;
    kill_idx_d   = kill_idx_q;
    kill_src_d   = kill_src_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (refresh_tick) state_d = S_LATCH;
      end
      S_LATCH: begin
        vld_d      = bul_valid;
        xl_d       = bul_xl;
        xr_d       = bul_xr;
        yt_d       = bul_yt;
        yb_d       = bul_yb;
        scan_idx_d = '0;
        flags_d    = 3'b000;
        state_d    = S_SCAN;
      end
      S_SCAN: begin
        if (is_brick) begin
          // Dead bricks are transparent; an alive one is claimed by one slot.
          if (cur_alive && (ovl != 3'b000)) begin
            alive_d[scan_idx_q] = 1'b0;
            flags_d             = flags_q | win_oh;
`ifdef BRICK_HIT_SCHED_KILL_LOG_EN
            kill_valid_d = 1'b1;
            kill_idx_d   = scan_idx_q;
            kill_src_d   = win_src;
`endif
          end
        end else begin
          flags_d = flags_q | ovl;
        end
        if (scan_idx_q == LAST_IDX) begin
          scan_idx_d = '0;
          state_d    = S_REPORT;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      S_REPORT: begin
        hit_d   = flags_q;
        done_d  = 1'b1;
        flags_d = 3'b000;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reload overrides everything, including a coincident tick in IDLE.
    if (map_reload) begin
      alive_d    = '1;
      state_d    = S_IDLE;
      scan_idx_d = '0;
      flags_d    = 3'b000;
      hit_d      = 3'b000;
      done_d     = 1'b0;
`ifdef BRICK_HIT_SCHED_KILL_LOG_EN
      kill_valid_d = 1'b0;
`endif
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      scan_idx_q <= '0;
      alive_q    <= '1;
      vld_q      <= '0;
      xl_q       <= '0;
      xr_q       <= '0;
      yt_q       <= '0;
      yb_q       <= '0;
      flags_q    <= '0;
      hit_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef BRICK_HIT_SCHED_KILL_LOG_EN
      kill_valid_q <= 1'b0;
      kill_idx_q   <= '0;
      kill_src_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      alive_q    <= alive_d;
      vld_q      <= vld_d;
      xl_q       <= xl_d;
      xr_q       <= xr_d;
      yt_q       <= yt_d;
      yb_q       <= yb_d;
      flags_q    <= flags_d;
      hit_q      <= hit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef BRICK_HIT_SCHED_KILL_LOG_EN
      kill_valid_q <= kill_valid_d;
      kill_idx_q   <= kill_idx_d;
      kill_src_q   <= kill_src_d;
`endif
    end
  end

  assign scan_idx    = scan_idx_q;
  assign brick_alive = alive_q;
  assign hit         = hit_q;
  assign busy        = busy_q;
  assign scan_done   = done_q;
`ifdef BRICK_HIT_SCHED_KILL_LOG_EN
  assign kill_valid  = kill_valid_q;
  assign kill_idx    = kill_idx_q;
  assign kill_src    = kill_src_q;
`endif

endmodule

// File: tb/tb_brick_hit_scheduler.sv
// ---------------------------------------------------------------------------
// tb_brick_hit_scheduler
//   Directed scenarios for brick_hit_scheduler. A per-object behavioural model
//   (tick accept, snapshot, one object per cycle, report) is compared against
//   the outputs every cycle; literal expectations pin latency, hit values and
//   brick bits for each scenario.
// ---------------------------------------------------------------------------
module tb_brick_hit_scheduler;

  localparam int NB   = 100;
  localparam int NI   = 10;
  localparam int NOBJ = NB + NI;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          refresh_tick = 1'b0;
  logic          map_reload = 1'b0;
  logic [2:0]    bul_valid = 3'b000;
  logic [29:0]   bul_xl = '0, bul_xr = '0, bul_yt = '0, bul_yb = '0;
  logic [6:0]    scan_idx;
  logic [9:0]    obj_x, obj_y;
  logic [NB-1:0] brick_alive;
  logic [2:0]    hit;
  logic          busy, scan_done;
`ifdef BRICK_HIT_SCHED_KILL_LOG_EN
  logic          kill_valid;
  logic [6:0]    kill_idx;
  logic [1:0]    kill_src;
`endif

  always #5 clk = ~clk;

  brick_hit_scheduler dut (
    .clk_50MHz    (clk),
    .reset        (rst_n),
    .refresh_tick (refresh_tick),
    .map_reload   (map_reload),
    .bul_valid    (bul_valid),
    .bul_xl       (bul_xl),
    .bul_xr       (bul_xr),
    .bul_yt       (bul_yt),
    .bul_yb       (bul_yb),
    .scan_idx     (scan_idx),
    .obj_x        (obj_x),
    .obj_y        (obj_y),
    .brick_alive  (brick_alive),
    .hit          (hit),
    .busy         (busy),
`ifdef BRICK_HIT_SCHED_KILL_LOG_EN
    .kill_valid   (kill_valid),
    .kill_idx     (kill_idx),
    .kill_src     (kill_src),
`endif
    .scan_done    (scan_done)
  );

  // Object position table: brick 0 (288,432), brick 20 (32,96), iron 0
  // (288,256); everything else parked away from the test boxes.
  function automatic logic [19:0] obj_pos(int i);
    int x, y;
    if (i == 0)            begin x = 288; y = 432; end
    else if (i == 20)      begin x = 32;  y = 96;  end
    else if (i < NB)       begin x = 512 + 48 * (i % 10); y = 512 + 32 * (i / 10); end
    else if (i == NB)      begin x = 288; y = 256; end
    else                   begin x = 64 * (i - NB); y = 900; end
    return {x[9:0], y[9:0]};
  endfunction

  logic [19:0] obj_p;
  assign obj_p = obj_pos(int'(scan_idx));
  assign obj_x = obj_p[19:10];
  assign obj_y = obj_p[9:0];

  int n_chk = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_cnt;
  logic [NB-1:0] m_alive;
  logic [2:0]    m_flags, m_hit, m_vld;
  logic          m_done, m_busy;
  int            m_xl[3], m_xr[3], m_yt[3], m_yb[3];
  logic          m_kv;
  int            m_ki, m_ks;

  function automatic logic [2:0] overlap(int o);
    logic [19:0] p;
    int ox, oy, sz;
    logic [2:0] r;
    p  = obj_pos(o);
    ox = int'(p[19:10]);
    oy = int'(p[9:0]);
    sz = (o < NB) ? 15 : 31;
    for (int k = 0; k < 3; k++)
      r[k] = m_vld[k] && (m_yt[k] < oy + sz) && (m_yb[k] > oy)
                      && (m_xl[k] < ox + sz) && (m_xr[k] > ox);
    return r;
  endfunction

  function automatic int first_slot(logic [2:0] v);
    if (v[0]) return 0;
    if (v[1]) return 1;
    return 2;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_alive <= '1; m_flags <= 0; m_hit <= 0; m_vld <= 0;
      m_done <= 0; m_busy <= 0; m_kv <= 0; m_ki <= 0; m_ks <= 0;
    end else begin
      m_hit  <= 0;
      m_done <= 0;
      m_kv   <= 0;
      if (map_reload) begin
        m_cnt <= 0; m_alive <= '1; m_flags <= 0; m_busy <= 0;
      end else if (m_cnt == 0) begin
        if (refresh_tick) begin m_cnt <= 1; m_busy <= 1; end
      end else if (m_cnt == 1) begin
        m_vld <= bul_valid;
        for (int k = 0; k < 3; k++) begin
          m_xl[k] <= int'(bul_xl[10*k +: 10]);
          m_xr[k] <= int'(bul_xr[10*k +: 10]);
          m_yt[k] <= int'(bul_yt[10*k +: 10]);
          m_yb[k] <= int'(bul_yb[10*k +: 10]);
        end
        m_flags <= 0;
        m_cnt   <= 2;
      end else if (m_cnt <= NOBJ + 1) begin
        if (m_cnt - 2 < NB) begin
          if (m_alive[m_cnt-2] && overlap(m_cnt - 2) != 3'b000) begin
            m_alive[m_cnt-2] <= 1'b0;
            m_flags[first_slot(overlap(m_cnt - 2))] <= 1'b1;
            m_kv <= 1'b1;
            m_ki <= m_cnt - 2;
            m_ks <= first_slot(overlap(m_cnt - 2));
          end
        end else begin
          m_flags <= m_flags | overlap(m_cnt - 2);
        end
        m_cnt <= m_cnt + 1;
      end else begin
        m_hit <= m_flags; m_done <= 1; m_busy <= 0; m_flags <= 0; m_cnt <= 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("hit", hit, m_hit);
      check("scan_done", scan_done, m_done);
      check("busy", busy, m_busy);
      check("brick_alive", brick_alive, m_alive);
`ifdef BRICK_HIT_SCHED_KILL_LOG_EN
      check("kill_valid", kill_valid, m_kv);
      if (m_kv) begin
        check("kill_idx", kill_idx, m_ki);
        check("kill_src", kill_src, m_ks);
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  int kill_cnt, kill_last_idx, kill_last_src;

  task automatic set_slot(input int k, input int xl, input int xr, input int yt, input int yb);
    bul_xl[10*k +: 10] = xl[9:0];
    bul_xr[10*k +: 10] = xr[9:0];
    bul_yt[10*k +: 10] = yt[9:0];
    bul_yb[10*k +: 10] = yb[9:0];
  endtask

  // Pulse a tick and wait for scan_done; optionally scramble the bullet
  // inputs after LATCH to show they are not re-sampled.
  task automatic run_scan(input string nm, input bit scramble, output logic [2:0] h);
    int j;
    logic [2:0]  sv;
    logic [29:0] sxl, sxr, syt, syb;
    @(negedge clk); refresh_tick = 1'b1;
    @(negedge clk); refresh_tick = 1'b0;
    j = 0; kill_cnt = 0; kill_last_idx = -1; kill_last_src = -1;
    sv = bul_valid; sxl = bul_xl; sxr = bul_xr; syt = bul_yt; syb = bul_yb;
    while (!scan_done && j < 300) begin
      @(negedge clk); j++;
`ifdef BRICK_HIT_SCHED_KILL_LOG_EN
      if (kill_valid) begin
        kill_cnt++; kill_last_idx = int'(kill_idx); kill_last_src = int'(kill_src);
      end
`endif
      if (j == 50) check({nm, " busy mid-scan"}, busy, 1'b1);
      if (scramble && j == 3) begin
        bul_valid = 3'b111;
        for (int k = 0; k < 3; k++) set_slot(k, 565, 570, 515, 520);
      end
    end
    if (scramble) begin
      bul_valid = sv; bul_xl = sxl; bul_xr = sxr; bul_yt = syt; bul_yb = syb;
    end
    check({nm, " latency"}, j, 112);
    check({nm, " busy at report"}, busy, 1'b0);
    h = hit;
  endtask

  task automatic expect_quiet(input string nm);
    int seen;
    seen = 0;
    repeat (150) begin
      @(negedge clk);
      if (scan_done || hit != 3'b000) seen++;
    end
    check({nm, " no report"}, seen, 0);
  endtask

  logic [2:0]    h;
  logic [NB-1:0] all_ones;

  initial begin
    all_ones = '1;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset hit", hit, 3'b000);
    check("reset busy", busy, 1'b0);
    check("reset scan_done", scan_done, 1'b0);
    check("reset scan_idx", scan_idx, 7'd0);
    check("reset brick_alive", brick_alive, all_ones);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // 1: player over brick 20
    bul_valid = 3'b001;
    set_slot(0, 40, 56, 96, 100);
    run_scan("s1", 1'b0, h);
    check("s1 hit", h, 3'b001);
    check("s1 brick20", brick_alive[20], 1'b0);
    check("s1 brick0", brick_alive[0], 1'b1);
`ifdef BRICK_HIT_SCHED_KILL_LOG_EN
    check("s1 kill count", kill_cnt, 1);
    check("s1 kill idx", kill_last_idx, 20);
    check("s1 kill src", kill_last_src, 0);
`endif
    @(negedge clk);
    check("s1 busy after", busy, 1'b0);

    // 4: same box, brick already gone
    run_scan("s4", 1'b0, h);
    check("s4 hit", h, 3'b000);

    // 2: player and enemy both on brick 0; inputs scrambled after LATCH
    bul_valid = 3'b011;
    set_slot(0, 290, 300, 440, 444);
    set_slot(1, 290, 300, 440, 444);
    run_scan("s2", 1'b1, h);
    check("s2 hit", h, 3'b001);
    check("s2 brick0", brick_alive[0], 1'b0);
    check("s2 brick1 untouched", brick_alive[1], 1'b1);

    // 3: enemy_2 on iron 0, invalid player box sitting on brick 1
    bul_valid = 3'b100;
    set_slot(0, 565, 570, 515, 520);
    set_slot(2, 300, 304, 260, 264);
    run_scan("s3a", 1'b0, h);
    check("s3a hit", h, 3'b100);
    run_scan("s3b", 1'b0, h);
    check("s3b hit", h, 3'b100);
    check("s3 brick1", brick_alive[1], 1'b1);

    // Reload coincident with tick in IDLE: reload wins
    @(negedge clk); refresh_tick = 1'b1; map_reload = 1'b1;
    @(negedge clk); refresh_tick = 1'b0; map_reload = 1'b0;
    check("reload+tick busy", busy, 1'b0);
    check("reload+tick alive", brick_alive, all_ones);
    expect_quiet("reload+tick");

    // 5a: extra tick during scan ignored, reload at index 40 aborts
    bul_valid = 3'b001;
    set_slot(0, 40, 56, 96, 100);
    @(negedge clk); refresh_tick = 1'b1;
    @(negedge clk); refresh_tick = 1'b0;
    repeat (5) @(negedge clk);
    refresh_tick = 1'b1;
    @(negedge clk); refresh_tick = 1'b0;
    repeat (35) @(negedge clk);
    check("s5a brick20 before reload", brick_alive[20], 1'b0);
    map_reload = 1'b1;
    @(negedge clk); map_reload = 1'b0;
    check("s5a busy after reload", busy, 1'b0);
    check("s5a alive after reload", brick_alive, all_ones);
    expect_quiet("s5a");

    // 5b: async reset at index 60
    @(negedge clk); refresh_tick = 1'b1;
    @(negedge clk); refresh_tick = 1'b0;
    repeat (61) @(negedge clk);
    check("s5b brick20 before reset", brick_alive[20], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("s5b busy in reset", busy, 1'b0);
    check("s5b alive in reset", brick_alive, all_ones);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    expect_quiet("s5b");

    // Normal operation after abort
    run_scan("s6", 1'b0, h);
    check("s6 hit", h, 3'b001);
    check("s6 brick20", brick_alive[20], 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
